axi_rd_arbiter: RTL

Shares one AXI4 master read channel between two single-word read requesters: port 0 is instruction fetch and port 1 is data load. It sits between the CPU core's fetch/memory stages and the AXI interconnect, in the ACLK domain. Each access is one single-beat 32-bit read, and only one transaction is outstanding at a time. Arbitration is two-way round-robin.

---
 rtl/cpu_axi_pkg.sv | 15 +
 rtl/rr_arb2.sv | 28 ++
 rtl/axi_rd_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/cpu_axi_pkg.sv
// rtl/cpu_axi_pkg.sv - shared read-arbiter state type and AXI4 encoding constants
package cpu_axi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } rd_state_e;

  localparam logic [2:0] SIZE_4B                     = 3'b010;
  localparam logic [1:0] BURST_INCR                  = 2'b01;
  localparam logic [3:0] CACHE_BUFFERABLE_MODIFIABLE = 4'b0011;
  localparam int         RESP_SLVERR_BIT             = 1;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter with last-grant pointer
module rr_arb2 (
  input  logic       ACLK,
  input  logic       ARESETN,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // last_q holds the index granted most recently; port 0 wins the first tie
  logic last_q;

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = last_q ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      last_q <= 1'b1;
    end else if (advance && (grant != 2'b00)) begin
      last_q <= grant[1];
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - shares one single-beat AXI4 read channel between fetch and load ports
module axi_rd_arbiter
  import cpu_axi_pkg::*;
#(
  parameter int C_M_AXI_THREAD_ID_WIDTH = 1,
  parameter int C_M_AXI_ADDR_WIDTH      = 32,
  parameter int C_M_AXI_DATA_WIDTH      = 32
) (
  input  logic                               ACLK,
  input  logic                               ARESETN,
  input  logic                               REQ0_VALID,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]      REQ0_ADDR,
  output logic                               REQ0_READY,
  input  logic                               REQ1_VALID,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]      REQ1_ADDR,
  output logic                               REQ1_READY,
  output logic                               RSP0_VALID,
  output logic                               RSP1_VALID,
  output logic [C_M_AXI_DATA_WIDTH-1:0]      RSP_DATA,
  output logic                               RSP_ERR,
  output logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_ARID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]      M_AXI_ARADDR,
  output logic [7:0]                         M_AXI_ARLEN,
  output logic [2:0]                         M_AXI_ARSIZE,
  output logic [1:0]                         M_AXI_ARBURST,
  output logic                               M_AXI_ARLOCK,
  output logic [3:0]                         M_AXI_ARCACHE,
  output logic [2:0]                         M_AXI_ARPROT,
  output logic [3:0]                         M_AXI_ARQOS,
  output logic                               M_AXI_ARUSER,
  output logic                               M_AXI_ARVALID,
  input  logic                               M_AXI_ARREADY,
  input  logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_RID,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]      M_AXI_RDATA,
  input  logic [1:0]                         M_AXI_RRESP,
  input  logic                               M_AXI_RLAST,
  input  logic                               M_AXI_RUSER,
  input  logic                               M_AXI_RVALID,
  output logic                               M_AXI_RREADY
);

  rd_state_e                    state_q, state_d;
  logic [1:0]                   grant;
  logic                         advance;
  logic                         gnt_q;
  logic [C_M_AXI_ADDR_WIDTH-1:0] araddr_q;
  logic [1:0]                   rsp_valid_q;
  logic [C_M_AXI_DATA_WIDTH-1:0] rsp_data_q;
  logic                         rsp_err_q;
  logic                         unused_inputs;

  assign advance = (state_q == IDLE) && (REQ0_VALID || REQ1_VALID);

  rr_arb2 u_arb (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .req     ({REQ1_VALID, REQ0_VALID}),
    .advance (advance),
    .grant   (grant)
  );

  assign REQ0_READY = advance && grant[0];
  assign REQ1_READY = advance && grant[1];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (advance)       state_d = ADDR;
      ADDR:    if (M_AXI_ARREADY) state_d = DATA;
      DATA:    if (M_AXI_RVALID)  state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q     <= IDLE;
      gnt_q       <= 1'b0;
      araddr_q    <= '0;
      rsp_valid_q <= 2'b00;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= 2'b00;
      if (advance) begin
        gnt_q    <= grant[1];
        araddr_q <= grant[1] ? {REQ1_ADDR[C_M_AXI_ADDR_WIDTH-1:2], 2'b00}
                             : {REQ0_ADDR[C_M_AXI_ADDR_WIDTH-1:2], 2'b00};
      end
      if ((state_q == DATA) && M_AXI_RVALID) begin
        rsp_data_q  <= M_AXI_RDATA;
        rsp_err_q   <= M_AXI_RRESP[RESP_SLVERR_BIT];
        rsp_valid_q <= gnt_q ? 2'b10 : 2'b01;
      end
    end
  end

  // Channel valids decode from the registered state only, so ARVALID never sees ARREADY
  assign M_AXI_ARVALID = (state_q == ADDR);
  assign M_AXI_RREADY  = (state_q == DATA);
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARID    = '0;
  assign M_AXI_ARLEN   = 8'd0;
  assign M_AXI_ARSIZE  = SIZE_4B;
  assign M_AXI_ARBURST = BURST_INCR;
  assign M_AXI_ARLOCK  = 1'b0;
  assign M_AXI_ARCACHE = CACHE_BUFFERABLE_MODIFIABLE;
  assign M_AXI_ARPROT  = 3'd0;
  assign M_AXI_ARQOS   = 4'd0;
  assign M_AXI_ARUSER  = 1'b0;

  assign RSP0_VALID = rsp_valid_q[0];
  assign RSP1_VALID = rsp_valid_q[1];
  assign RSP_DATA   = rsp_data_q;
  assign RSP_ERR    = rsp_err_q;

  assign unused_inputs = ^{M_AXI_RID, M_AXI_RUSER, M_AXI_RLAST, M_AXI_RRESP[0],
                           REQ0_ADDR[1:0], REQ1_ADDR[1:0]};

endmodule
